fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage feeding the 16-bit CPU core. Owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small prefetch queue. The core pulls instructions over a valid/ready handshake. Branch and jump redirects from the core flush the queue and restart fetch.

## Interface
- `ADDR_W`, 10: instruction memory word-address width.
- `DEPTH`, 4: prefetch queue entries; power of two, at least 2.
- `RESET_PC`, 16'h0000: fetch PC after reset.

- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `imem_req` out 1: read request; registered.
- `imem_addr` out ADDR_W: word address, equal to `fetch_pc[ADDR_W-1:0]`; registered.
- `imem_ack` in 1: transfer completes on an edge where `imem_req && imem_ack`.
- `imem_rdata` in 16: instruction word; valid in the ack cycle.
- `redirect` in 1: flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc` in 16: new fetch PC.
- `inst_valid` out 1: queue head is valid.
- `inst_ready` in 1: core accepts the head on an edge where `inst_valid && inst_ready`.
- `instruction` out 16: head instruction; 0 when empty.
- `inst_pc` out 16: PC of the head instruction; 0 when empty.
- `fifo_count` out $clog2(DEPTH+1): current occupancy.

## Operation
- PC counts instruction words and increments by 1 per fetched instruction. It wraps from 16'hFFFF to 0. `imem_addr` truncates the PC to its low `ADDR_W` bits.
- At most one outstanding request. While `imem_req` is high, the request and `imem_addr` stay stable until ack.
- FSM states:
  - IDLE: `imem_req`=0. Moves to FETCH when `count < DEPTH`.
  - FETCH: `imem_req`=1. On ack, pushes {rdata, fetch_pc} and sets `fetch_pc`+1. It stays in FETCH if post-edge count < DEPTH; otherwise it goes to IDLE.
  - DRAIN: `imem_req`=1 holding the stale address. On ack, the data is discarded and the FSM goes to FETCH, because the queue has already been flushed.
- Redirect, evaluated in priority over all else:
  - The queue is flushed (count to 0) and `fetch_pc` is set to `redirect_pc`.
  - FETCH without ack goes to DRAIN.
  - FETCH with ack in the same cycle discards the data and goes to FETCH at `redirect_pc`.
  - DRAIN without ack stays in DRAIN and takes the new PC.
  - DRAIN with ack goes to FETCH.
  - IDLE goes to FETCH.
- A pop in the redirect cycle still counts as consumed by the core. The flush applies afterward.
- Simultaneous push and pop in one cycle leaves count unchanged. Both pointers advance modulo DEPTH.
- A push never occurs when full. A request is only issued with `count < DEPTH`, and count cannot grow while that request is pending.

## Timing
- Reset values: state IDLE, `imem_req`=0, `imem_addr`=RESET_PC[ADDR_W-1:0], `fetch_pc`=RESET_PC, count=0, `inst_valid`=0, `instruction`=0, `inst_pc`=0.
- After reset deasserts, the first edge moves IDLE to FETCH. `imem_req` is high in the following cycle.
- Latency from ack edge to `inst_valid`: 1 cycle. There is no bypass.
- Throughput is 1 instruction per cycle when the memory acks every cycle and the core pops every cycle.
- After redirect, `inst_valid`=0 starting the next cycle. The first new instruction arrives one cycle after its ack.
- Reset asserted mid-transfer returns everything to the reset values immediately. Any ack that arrives later is not sampled.

## Structure
- Shared package `cpu_pkg` holds:
  - `INST_W`=16 and `PC_W`=16.
  - the `fetch_state_t` enum (IDLE, FETCH, DRAIN).
  - the queue entry struct {instruction, pc}.
- Sub-module `fetch_queue` is a synchronous FIFO with a `flush` input, push/pop ports, `count`, and a head read. The FSM and PC logic sit in `fetch_unit`.

## Test plan
- Reset release, ack tied high, `inst_ready`=1 → `imem_addr` 0,1,2,…. `inst_pc` 0,1,2,… appears 1 cycle after each ack. `instruction` matches memory.
- `inst_ready`=0 → exactly 4 entries are fetched, `fifo_count`=4, and `imem_req` drops (IDLE). One pop → exactly one new request, and count returns to 4.
- Ack delayed 3 cycles → `imem_req` and `imem_addr` are held stable across all 3 cycles.
- Redirect to 16'h0100 while a request to 0x002 is pending → FSM enters DRAIN and the 0x002 data is dropped. The next request address is 0x100, and the first `inst_pc` is 16'h0100.
- Redirect coincident with ack and a pop → the popped entry counts as consumed and the acked data is discarded. The queue is empty the next cycle, and the next fetch is at `redirect_pc`.
- `RESET_PC`=16'hFFFE → `inst_pc` sequence FFFE, FFFF, 0000. `imem_addr` sequence 0x3FE, 0x3FF, 0x000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit CPU front end: widths, fetch FSM states and the
// prefetch queue entry layout.
package cpu_pkg;

  localparam int INST_W = 16;
  localparam int PC_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] instruction;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of {instruction, pc} entries with a
// single-cycle flush. Head outputs read as zero while empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [INST_W-1:0] push_inst_i,
  input  logic [PC_W-1:0]   push_pc_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [INST_W-1:0] head_inst_o,
  output logic [PC_W-1:0]   head_pc_o,
  output logic [CNT_W-1:0]  count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: storage needs no reset; count_q gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= '{instruction: push_inst_i, pc: push_pc_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign valid_o     = (count_q != '0);
  assign head_inst_o = valid_o ? mem_q[rd_ptr_q].instruction : '0;
  assign head_pc_o   = valid_o ? mem_q[rd_ptr_q].pc : '0;
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs one outstanding req/ack read
// at a time into instruction memory and buffers results in a prefetch queue.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter  int              ADDR_W   = 10,
  parameter  int              DEPTH    = 4,
  parameter  logic [PC_W-1:0] RESET_PC = 16'h0000,
  localparam int              CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] instruction,
  output logic [PC_W-1:0]   inst_pc,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              acked;
  logic              do_push;
  logic              do_pop;
  logic [CNT_W-1:0]  count_after;

  assign acked       = req_q && imem_ack;
  assign do_pop      = inst_valid && inst_ready;
  assign do_push     = (state_q == FETCH) && acked && !redirect;
  assign count_after = fifo_count + CNT_W'(do_push) - CNT_W'(do_pop);

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      // A request still in flight must be allowed to complete before refetching.
      state_d    = (state_q == IDLE || acked) ? FETCH : DRAIN;
    end else begin
      case (state_q)
        IDLE:  if (fifo_count < FULL_CNT) state_d = FETCH;
        FETCH: if (acked) begin
                 fetch_pc_d = fetch_pc_q + 1'b1;
                 state_d    = (count_after < FULL_CNT) ? FETCH : IDLE;
               end
        DRAIN: if (acked) state_d = FETCH;
        default: state_d = IDLE;
      endcase
    end
    req_d  = (state_d != IDLE);
    // DRAIN keeps presenting the stale address until its ack retires it.
    addr_d = (state_d == DRAIN) ? addr_q : fetch_pc_d[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC[ADDR_W-1:0];
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (redirect),
    .push_i     (do_push),
    .push_inst_i(imem_rdata),
    .push_pc_i  (fetch_pc_q),
    .pop_i      (do_pop),
    .valid_o    (inst_valid),
    .head_inst_o(instruction),
    .head_pc_o  (inst_pc),
    .count_o    (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns 16'hC000 | address so every
// expected instruction word is known from its address.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;

  logic        imem_req, imem_ack, redirect, inst_valid, inst_ready;
  logic [9:0]  imem_addr;
  logic [15:0] imem_rdata, redirect_pc, instruction, inst_pc;
  logic [2:0]  fifo_count;

  logic        imem_req2, imem_ack2, redirect2, inst_valid2, inst_ready2;
  logic [9:0]  imem_addr2;
  logic [15:0] imem_rdata2, redirect_pc2, instruction2, inst_pc2;
  logic [2:0]  fifo_count2;

  int total = 0;
  int bad   = 0;

  assign imem_rdata  = 16'hC000 | {6'b0, imem_addr};
  assign imem_rdata2 = 16'hC000 | {6'b0, imem_addr2};

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc), .fifo_count(fifo_count)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .redirect(redirect2), .redirect_pc(redirect_pc2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready2),
    .instruction(instruction2), .inst_pc(inst_pc2), .fifo_count(fifo_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  logic [15:0] exp_pc2   [3];
  logic [9:0]  exp_addr2 [3];

  initial begin
    exp_pc2   = '{16'hFFFE, 16'hFFFF, 16'h0000};
    exp_addr2 = '{10'h3FF, 10'h000, 10'h001};

    reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b1; inst_ready = 1'b1;
    redirect2 = 1'b0; redirect_pc2 = '0; imem_ack2 = 1'b1; inst_ready2 = 1'b1;

    // Reset values
    tick(); tick();
    check("rst_req",   imem_req,    0);
    check("rst_addr",  imem_addr,   0);
    check("rst_valid", inst_valid,  0);
    check("rst_inst",  instruction, 0);
    check("rst_pc",    inst_pc,     0);
    check("rst_count", fifo_count,  0);
    check("rst_addr2", imem_addr2,  10'h3FE);
    check("rst_req2",  imem_req2,   0);

    // Streaming: ack every cycle, pop every cycle
    reset = 1'b1;
    tick();
    check("s_req1",   imem_req,   1);
    check("s_addr1",  imem_addr,  0);
    check("s_valid1", inst_valid, 0);
    check("s_addr2",  imem_addr2, 10'h3FE);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s_pc",    inst_pc,     32'(i));
      check("s_inst",  instruction, 32'h0000C000 + 32'(i));
      check("s_addr",  imem_addr,   32'(i + 1));
      check("s_count", fifo_count,  1);
      if (i < 3) begin
        check("w_pc2",   inst_pc2,     exp_pc2[i]);
        check("w_inst2", instruction2, 16'hC000 | {6'b0, exp_pc2[i][9:0]});
        check("w_addr2", imem_addr2,   exp_addr2[i]);
      end
    end

    // Backpressure: queue fills to DEPTH, then one pop allows one refill
    inst_ready = 1'b0; imem_ack = 1'b1;
    do_reset();
    tick();
    check("f_req1", imem_req, 1);
    repeat (4) tick();
    check("f_count", fifo_count, 4);
    check("f_req0",  imem_req,   0);
    check("f_addr",  imem_addr,  4);
    check("f_head",  inst_pc,    0);
    tick(); tick();
    check("f_idle_req",   imem_req,   0);
    check("f_idle_count", fifo_count, 4);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("p_count", fifo_count, 3);
    check("p_head",  inst_pc,    1);
    check("p_req",   imem_req,   0);
    tick();
    check("p_req1",   imem_req,   1);
    check("p_addr",   imem_addr,  4);
    check("p_count3", fifo_count, 3);
    tick();
    check("p_refill", fifo_count, 4);
    check("p_req_off", imem_req,  0);
    tick();
    check("p_one_req", imem_req,  0);
    check("p_still4",  fifo_count, 4);

    // Slow memory: request held stable for three cycles
    imem_ack = 1'b0; inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d_req",  imem_req,  1);
      check("d_addr", imem_addr, 0);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("d_valid", inst_valid,  1);
    check("d_pc",    inst_pc,     0);
    check("d_inst",  instruction, 16'hC000);
    check("d_next",  imem_addr,   1);

    // Redirect with a pending request: DRAIN drops the stale data
    imem_ack = 1'b1; inst_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    check("r_addr2",  imem_addr,  2);
    check("r_count2", fifo_count, 2);
    imem_ack = 1'b0;
    tick();
    check("r_pend", imem_addr, 2);
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    check("r_drain_req",  imem_req,   1);
    check("r_drain_addr", imem_addr,  2);
    check("r_flush_val",  inst_valid, 0);
    check("r_flush_cnt",  fifo_count, 0);
    imem_ack = 1'b1;
    tick();
    check("r_new_addr", imem_addr,  10'h100);
    check("r_dropped",  fifo_count, 0);
    check("r_noval",    inst_valid, 0);
    inst_ready = 1'b1;
    tick();
    check("r_first_val",  inst_valid,  1);
    check("r_first_pc",   inst_pc,     16'h0100);
    check("r_first_inst", instruction, 16'hC100);

    // Redirect together with ack and pop
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    check("x_valid", inst_valid,  0);
    check("x_count", fifo_count,  0);
    check("x_inst",  instruction, 0);
    check("x_pc",    inst_pc,     0);
    check("x_addr",  imem_addr,   10'h200);
    check("x_req",   imem_req,    1);
    tick();
    check("x_new_pc",   inst_pc,     16'h0200);
    check("x_new_inst", instruction, 16'hC200);
    check("x_new_cnt",  fifo_count,  1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
